mc_trace_buffer: RTL and testbench
==================================

# mc_trace_buffer

On-chip retirement trace buffer for the multi-cycle CPU. It captures one record per retired instruction: PC, instruction word, and register writeback. Capture starts on an arm command plus an optional PC-match trigger, and the buffer supports stop-when-full and circular (pre-trigger history) modes. Sits beside `ManyCycleCPU`, fed from its writeback-stage signals; drained afterwards through a valid/ready readout port by the bench or a debug UART.

## Interface
- `DATA_W`, 32: PC, instruction and writeback data width.
- `REG_W`, 5: register-index width.
- `DEPTH`, 16: record slots; power of 2, ≥ 2.
- `POST`, 8: records captured from the trigger onward in circular mode; 1 ≤ POST ≤ DEPTH.

Ports:
- `CLK` in 1: single clock; all state on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `arm` in 1: one-cycle pulse; clears the buffer and starts a new capture session.
- `mode` in 1: sampled at `arm`. 0 = stop-when-full, 1 = circular.
- `trig_en` in 1: sampled at `arm`. 1 = wait for PC match, 0 = first retired record triggers.
- `trig_pc` in DATA_W: trigger PC, sampled at `arm`.
- `ret_valid` in 1: a retirement record is present this cycle.
- `ret_pc`, `ret_ins`, `ret_wr_data` in DATA_W: PC, instruction and writeback data of the record.
- `ret_wr_reg` in REG_W, `ret_wr_en` in 1: writeback target register and its write enable.
- `rd_ready` in 1: consumer accepts the head record.
- `rd_valid` out 1: a head record is available.
- `rd_pc`, `rd_ins`, `rd_wr_data` out DATA_W; `rd_wr_reg` out REG_W; `rd_wr_en` out 1: fields of the head record.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- `count` out $clog2(DEPTH+1): records held.
- `overflow` out 1: sticky; at least one record was overwritten in circular mode.

## Operation
- Reset values: state IDLE, count 0, read/write pointers 0, overflow 0, rd_valid 0, all rd_* fields 0. Latched mode/trig_en/trig_pc are 0.
- `arm`, from any state:
  - Latches `mode`, `trig_en` and `trig_pc`.
  - Clears the pointers, count, overflow and the post-trigger counter.
  - Moves to ARMED.
  - Has priority over every other event in the same cycle; any record or pop in that cycle is discarded.
- Trigger hit is `ret_valid && (!trig_en_q || ret_pc == trig_pc)` while in ARMED.
- ARMED:
  - Mode 0: records are not stored. On a hit, the hit record is written and the state moves to CAPTURE.
  - Mode 1: every valid record is written. A hit moves the state to CAPTURE with the post counter set to 1. If POST == 1, a hit goes straight to DONE.
- CAPTURE:
  - Each valid record is written.
  - Mode 0: when the write brings count to DEPTH, move to DONE.
  - Mode 1: each write increments the post counter; when it reaches POST, move to DONE.
- Circular full write (count == DEPTH, mode 1):
  - Overwrite the slot at the write pointer.
  - Advance both the read and write pointers.
  - count stays DEPTH and overflow is set to 1.
- Mode 0 cannot overflow, because it stops at full.
- DONE:
  - Records are ignored.
  - `rd_valid = (count != 0)`; the rd_* fields show the slot at the read pointer.
  - A pop (`rd_valid && rd_ready`) advances the read pointer and decrements count.
  - The state stays DONE at count 0 until the next `arm`.
- IDLE: records are ignored and rd_valid is 0.
- Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- A record presented at edge N is reflected in count and state after edge N; it is readable in DONE with zero added latency.
- Readout is a combinational read of the head slot. A pop at edge N presents the next record immediately after N, so one record per cycle is sustained.
- The state transition to DONE and the last write occur on the same edge. rd_valid can be high in the cycle after the final capture.
- The trigger compare is combinational on `ret_pc`, with no pipeline.
- Reset asserted mid-capture or mid-readout returns every register to its reset value asynchronously. Stored memory contents are don't-care.

## Structure
- Package `mc_trace_pkg` holds:
  - the state encoding localparams (ST_IDLE..ST_DONE);
  - the record width `REC_W(DATA_W,REG_W) = 3*DATA_W + REG_W + 1`;
  - the field offsets for packing and unpacking a record.
- Sub-module `mc_trace_ram`: a DEPTH×REC_W register array with one synchronous write port and an asynchronous read. The top level holds the FSM, pointers, counters and trigger logic.

## Test plan
- DEPTH=4, mode 0, trig_en=0; retire PCs 0x00,0x04,0x08,0x0C,0x10 → DONE after the 4th; read out 0x00..0x0C; count returns to 0; 0x10 is absent; overflow=0.
- Mode 0, trig_en=1, trig_pc=0xF8; retire 0x00,0x04,0xF8,0xFC,0x100,0x104 → the first read record is 0xF8; the buffer holds 0xF8..0x104; DONE.
- DEPTH=4, POST=2, mode 1, trig_pc=0x20; retire 0x10,0x14,0x18,0x1C,0x20,0x24 → DONE; readout is 0x18,0x1C,0x20,0x24; overflow=1.
- In DONE, hold rd_ready=1 for 4 cycles → one record per cycle; rd_valid drops when count reaches 0; state stays DONE; `arm` returns the state to ARMED with count 0.
- `arm` in the same cycle as a pop and a ret_valid → count 0, ARMED, overflow 0, and neither record nor pop takes effect.
- Assert Reset low mid-CAPTURE with count=3 → immediately IDLE, count 0, rd_valid 0; after release, records are ignored until `arm`.

Source files
------------

// File: rtl/mc_trace_pkg.sv
// Shared definitions for the retirement trace buffer: state encoding and
// record layout helpers used by the top level and its storage array.
package mc_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_e;

   // Record layout, LSB first: wr_en | wr_reg | wr_data | ins | pc
   localparam int OFF_WR_EN  = 0;
   localparam int OFF_WR_REG = 1;

   function automatic int rec_w(input int data_w, input int reg_w);
      return 3*data_w + reg_w + 1;
   endfunction

   function automatic int off_wr_data(input int reg_w);
      return 1 + reg_w;
   endfunction

   function automatic int off_ins(input int data_w, input int reg_w);
      return 1 + reg_w + data_w;
   endfunction

   function automatic int off_pc(input int data_w, input int reg_w);
      return 1 + reg_w + 2*data_w;
   endfunction

endpackage

// File: rtl/mc_trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; only the pointers in the parent qualify them.
module mc_trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 102
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mc_trace_buffer.sv
// Retirement trace buffer: arm/trigger FSM, pointers and counters around a
// record array, drained through a valid/ready port once the session is done.
//
// state      | meaning
// ST_IDLE    | no session; records ignored, nothing readable
// ST_ARMED   | waiting for trigger; circular mode keeps pre-trigger history
// ST_CAPTURE | trigger seen; storing records until full / POST reached
// ST_DONE    | capture finished; records ignored, head record readable
module mc_trace_buffer
   import mc_trace_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 16,
   parameter int POST   = 8
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       arm,
   input  logic                       mode,
   input  logic                       trig_en,
   input  logic [DATA_W-1:0]          trig_pc,
   input  logic                       ret_valid,
   input  logic [DATA_W-1:0]          ret_pc,
   input  logic [DATA_W-1:0]          ret_ins,
   input  logic [DATA_W-1:0]          ret_wr_data,
   input  logic [REG_W-1:0]           ret_wr_reg,
   input  logic                       ret_wr_en,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_pc,
   output logic [DATA_W-1:0]          rd_ins,
   output logic [DATA_W-1:0]          rd_wr_data,
   output logic [REG_W-1:0]           rd_wr_reg,
   output logic                       rd_wr_en,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int PST_W   = $clog2(POST+1);
   localparam int REC_W   = rec_w(DATA_W, REG_W);
   localparam int O_WDATA = off_wr_data(REG_W);
   localparam int O_INS   = off_ins(DATA_W, REG_W);
   localparam int O_PC    = off_pc(DATA_W, REG_W);

   trace_state_e      state_q, state_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PST_W-1:0]  post_q, post_d;
   logic              ovf_q, ovf_d;
   logic              mode_q, mode_d, trig_en_q, trig_en_d;
   logic [DATA_W-1:0] trig_pc_q, trig_pc_d;

   logic              wr_en, hit, full;
   logic [REC_W-1:0]  wr_rec, rd_rec;

   assign hit    = ret_valid && (!trig_en_q || (ret_pc == trig_pc_q));
   assign full   = (cnt_q == CNT_W'(DEPTH));
   assign wr_rec = {ret_pc, ret_ins, ret_wr_data, ret_wr_reg, ret_wr_en};

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      post_d    = post_q;
      ovf_d     = ovf_q;
      mode_d    = mode_q;
      trig_en_d = trig_en_q;
      trig_pc_d = trig_pc_q;
      wr_en     = 1'b0;

      if (arm) begin
         mode_d    = mode;
         trig_en_d = trig_en;
         trig_pc_d = trig_pc;
         wptr_d    = '0;
         rptr_d    = '0;
         cnt_d     = '0;
         post_d    = '0;
         ovf_d     = 1'b0;
         state_d   = ST_ARMED;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (!mode_q) begin
                  if (hit) begin
                     wr_en   = 1'b1;
                     state_d = ST_CAPTURE;
                  end
               end else begin
                  wr_en = ret_valid;
                  if (hit) begin
                     post_d  = PST_W'(1);
                     state_d = (POST == 1) ? ST_DONE : ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               if (ret_valid) begin
                  wr_en = 1'b1;
                  if (!mode_q) begin
                     if (cnt_q == CNT_W'(DEPTH-1)) state_d = ST_DONE;
                  end else begin
                     post_d = post_q + PST_W'(1);
                     if (post_q == PST_W'(POST-1)) state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (rd_valid && rd_ready) begin
                  rptr_d = rptr_q + PTR_W'(1);
                  cnt_d  = cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase

         // A write into a full circular buffer drops the oldest record.
         if (wr_en) begin
            wptr_d = wptr_q + PTR_W'(1);
            if (full) begin
               rptr_d = rptr_q + PTR_W'(1);
               ovf_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         post_q    <= '0;
         ovf_q     <= 1'b0;
         mode_q    <= 1'b0;
         trig_en_q <= 1'b0;
         trig_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         post_q    <= post_d;
         ovf_q     <= ovf_d;
         mode_q    <= mode_d;
         trig_en_q <= trig_en_d;
         trig_pc_q <= trig_pc_d;
      end
   end

   mc_trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (wr_en),
      .waddr_i (wptr_q),
      .wdata_i (wr_rec),
      .raddr_i (rptr_q),
      .rdata_o (rd_rec)
   );

   assign rd_valid   = (state_q == ST_DONE) && (cnt_q != '0);
   assign rd_pc      = rd_valid ? rd_rec[O_PC +: DATA_W]       : '0;
   assign rd_ins     = rd_valid ? rd_rec[O_INS +: DATA_W]      : '0;
   assign rd_wr_data = rd_valid ? rd_rec[O_WDATA +: DATA_W]    : '0;
   assign rd_wr_reg  = rd_valid ? rd_rec[OFF_WR_REG +: REG_W]  : '0;
   assign rd_wr_en   = rd_valid ? rd_rec[OFF_WR_EN]            : 1'b0;
   assign state      = state_q;
   assign count      = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_mc_trace_buffer.sv
// Scoreboard bench for mc_trace_buffer: a queue-based reference model fills
// the expected readout, and a monitor checks status and popped records.
module tb_mc_trace_buffer;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int DEPTH  = 4;
   localparam int POST   = 2;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              CLK = 1'b0;
   logic              Reset;
   logic              arm, mode, trig_en;
   logic [DATA_W-1:0] trig_pc;
   logic              ret_valid;
   logic [DATA_W-1:0] ret_pc, ret_ins, ret_wr_data;
   logic [REG_W-1:0]  ret_wr_reg;
   logic              ret_wr_en;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_pc, rd_ins, rd_wr_data;
   logic [REG_W-1:0]  rd_wr_reg;
   logic              rd_wr_en;
   logic [1:0]        state;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   mc_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .POST(POST)) dut (
      .CLK(CLK), .Reset(Reset), .arm(arm), .mode(mode), .trig_en(trig_en),
      .trig_pc(trig_pc), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ins(ret_ins),
      .ret_wr_data(ret_wr_data), .ret_wr_reg(ret_wr_reg), .ret_wr_en(ret_wr_en),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ins(rd_ins),
      .rd_wr_data(rd_wr_data), .rd_wr_reg(rd_wr_reg), .rd_wr_en(rd_wr_en),
      .state(state), .count(count), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [DATA_W-1:0] pc, ins, wd;
      logic [REG_W-1:0]  wr;
      logic              we;
   } rec_t;

   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: session contents as a plain queue of records.
   int   m_state = 0;
   rec_t m_q[$];
   rec_t exp_q[$];
   logic [DATA_W-1:0] got_pc[$];
   bit   m_ovf = 0, m_mode = 0, m_ten = 0;
   logic [DATA_W-1:0] m_tpc = '0;
   int   m_post = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rec_t cur_rec();
      rec_t r;
      r.pc = ret_pc; r.ins = ret_ins; r.wd = ret_wr_data; r.wr = ret_wr_reg; r.we = ret_wr_en;
      return r;
   endfunction

   always @(posedge CLK or negedge Reset) begin
      int  prev;
      bit  hit;
      prev = m_state;
      if (!Reset) begin
         m_state = 0; m_q.delete(); exp_q.delete(); m_ovf = 0;
         m_mode = 0; m_ten = 0; m_tpc = '0; m_post = 0;
      end else if (arm) begin
         m_mode = mode; m_ten = trig_en; m_tpc = trig_pc;
         m_q.delete(); exp_q.delete(); m_ovf = 0; m_post = 0; m_state = 1;
      end else begin
         hit = ret_valid && (!m_ten || ret_pc == m_tpc);
         if (m_state == 1) begin
            if (!m_mode) begin
               if (hit) begin m_q.push_back(cur_rec()); m_state = 2; end
            end else begin
               if (ret_valid) begin
                  m_q.push_back(cur_rec());
                  if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
               end
               if (hit) begin m_post = 1; m_state = (m_post >= POST) ? 3 : 2; end
            end
         end else if (m_state == 2) begin
            if (ret_valid) begin
               m_q.push_back(cur_rec());
               if (!m_mode) begin
                  if (m_q.size() == DEPTH) m_state = 3;
               end else begin
                  if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
                  m_post++;
                  if (m_post == POST) m_state = 3;
               end
            end
         end else if (m_state == 3) begin
            if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
         end
         if (prev != 3 && m_state == 3) exp_q = m_q;
      end
   end

   always @(negedge CLK) begin
      rec_t e;
      chk("state", 64'(state), 64'(m_state));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid), 64'(m_state == 3 && m_q.size() != 0));
      if (rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_pop: got pc %0h, expected no record", rd_pc);
         end else begin
            e = exp_q.pop_front();
            chk("rd_pc", 64'(rd_pc), 64'(e.pc));
            chk("rd_ins", 64'(rd_ins), 64'(e.ins));
            chk("rd_wr_data", 64'(rd_wr_data), 64'(e.wd));
            chk("rd_wr_reg", 64'(rd_wr_reg), 64'(e.wr));
            chk("rd_wr_en", 64'(rd_wr_en), 64'(e.we));
            got_pc.push_back(rd_pc);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_rec(input logic [DATA_W-1:0] pc);
      ret_pc      = pc;
      ret_ins     = $urandom;
      ret_wr_data = $urandom;
      ret_wr_reg  = REG_W'($urandom);
      ret_wr_en   = 1'($urandom);
   endtask

   task automatic do_arm(input bit md, input bit te, input logic [DATA_W-1:0] tpc);
      arm = 1'b1; mode = md; trig_en = te; trig_pc = tpc;
      step();
      arm = 1'b0;
   endtask

   task automatic retire(input logic [DATA_W-1:0] pc);
      ret_valid = 1'b1;
      set_rec(pc);
      step();
      ret_valid = 1'b0;
   endtask

   task automatic drain_check(input string name, input logic [DATA_W-1:0] e0,
                              input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                              input logic [DATA_W-1:0] e3);
      logic [DATA_W-1:0] ev [4];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      got_pc.delete();
      rd_ready = 1'b1;
      repeat (4) step();
      rd_ready = 1'b0;
      chk({name, "_len"}, 64'(got_pc.size()), 64'd4);
      for (int i = 0; i < 4 && i < got_pc.size(); i++) chk({name, "_pc"}, 64'(got_pc[i]), 64'(ev[i]));
      chk({name, "_cnt0"}, 64'(count), 64'd0);
      chk({name, "_done"}, 64'(state), 64'd3);
      chk({name, "_valid0"}, 64'(rd_valid), 64'd0);
   endtask

   initial begin
      bit early, done;
      Reset = 1'b0; arm = 0; mode = 0; trig_en = 0; trig_pc = '0;
      ret_valid = 0; ret_pc = '0; ret_ins = '0; ret_wr_data = '0; ret_wr_reg = '0;
      ret_wr_en = 0; rd_ready = 0;
      #2;
      chk("rst_pc", 64'(rd_pc), 64'd0);
      chk("rst_ins", 64'(rd_ins), 64'd0);
      chk("rst_wd", 64'(rd_wr_data), 64'd0);
      chk("rst_reg", 64'({rd_wr_reg, rd_wr_en}), 64'd0);
      step(); step();
      Reset = 1'b1;
      step();

      // stop-when-full, immediate trigger; fifth record ignored
      do_arm(0, 0, '0);
      for (int i = 0; i < 5; i++) retire(DATA_W'(i * 4));
      chk("t1_state", 64'(state), 64'd3);
      chk("t1_ovf", 64'(overflow), 64'd0);
      drain_check("t1", 'h00, 'h04, 'h08, 'h0C);
      do_arm(0, 0, '0);
      chk("rearm_state", 64'(state), 64'd1);
      chk("rearm_cnt", 64'(count), 64'd0);

      // stop-when-full with PC trigger
      do_arm(0, 1, 'hF8);
      retire('h00); retire('h04);
      chk("t2_armed", 64'(state), 64'd1);
      retire('hF8); retire('hFC); retire('h100); retire('h104);
      drain_check("t2", 'hF8, 'hFC, 'h100, 'h104);

      // circular with pre-trigger history
      do_arm(1, 1, 'h20);
      for (int i = 0; i < 6; i++) retire(DATA_W'('h10 + i * 4));
      chk("t3_state", 64'(state), 64'd3);
      chk("t3_ovf", 64'(overflow), 64'd1);
      drain_check("t3", 'h18, 'h1C, 'h20, 'h24);

      // arm collides with a pop and a record
      do_arm(1, 1, 'h20);
      for (int i = 0; i < 6; i++) retire(DATA_W'('h10 + i * 4));
      arm = 1; mode = 0; trig_en = 0; rd_ready = 1; ret_valid = 1; set_rec('h40);
      step();
      arm = 0; rd_ready = 0; ret_valid = 0;
      chk("col_state", 64'(state), 64'd1);
      chk("col_cnt", 64'(count), 64'd0);
      chk("col_ovf", 64'(overflow), 64'd0);

      // async reset mid-capture
      retire('h0); retire('h4); retire('h8);
      chk("prerst_cnt", 64'(count), 64'd3);
      #2 Reset = 1'b0;
      #1;
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_cnt", 64'(count), 64'd0);
      chk("arst_valid", 64'(rd_valid), 64'd0);
      @(negedge CLK);
      Reset = 1'b1;
      step();
      retire('h0); retire('h4);
      chk("idle_cnt", 64'(count), 64'd0);
      chk("idle_state", 64'(state), 64'd0);

      // randomized sessions
      for (int s = 0; s < 40; s++) begin
         ret_valid = 1'($urandom); set_rec(DATA_W'(($urandom % 16) * 4));
         rd_ready = 1'($urandom);
         do_arm(1'($urandom), 1'($urandom), DATA_W'(($urandom % 16) * 4));
         early = ($urandom % 4 == 0);
         done = 0;
         for (int c = 0; c < 400 && !done; c++) begin
            ret_valid = ($urandom % 4 != 0);
            set_rec(DATA_W'(($urandom % 16) * 4));
            rd_ready = ($urandom % 3 != 0);
            step();
            if (m_state == 3 && (m_q.size() == 0 || early)) done = 1;
         end
         ret_valid = 0; rd_ready = 0;
         if (!done) begin
            n_vec++; n_err++;
            $display("FAIL session_timeout: session %0d state %0d, expected drained DONE", s, state);
         end
      end
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
